adc_trigger_capture: RTL and testbench

Next-generation multi-channel ADC trigger and capture front end. It converts NUM_CH raw ADC lanes to signed samples and forms an absolute-sum trigger metric. A hysteresis trigger state machine opens a capture window. Each window streams pre-trigger plus in-window samples, each tagged with a timestamp, on an AXI4-Stream master with tready backpressure, tlast framing, a length limit and drop accounting.

---
 rtl/adc_trigger_capture.sv | 194 +++++++++++++++++++
 tb/tb_adc_trigger_capture.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_trigger_capture.sv
// ADC lane conversion, abs-sum trigger metric and hysteresis trigger that
// streams pre-trigger plus in-window samples with timestamps over AXI4-Stream.
module adc_trigger_capture #(
    parameter int ADC_DATA_WIDTH = 14,
    parameter int NUM_CH         = 2,
    parameter int PRE_DEPTH      = 16,
    parameter int TS_WIDTH       = 48
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [16*NUM_CH-1:0] adc_dat,
    input  logic [15:0]          level_hi,
    input  logic [15:0]          level_lo,
    input  logic [31:0]          max_len,
    input  logic                 auto_rearm,
    input  logic                 arm,
    input  logic                 clear_stats,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic [63:0]          m_axis_tdata,
    output logic                 m_axis_tlast,
    output logic [15:0]          cur_metric,
    output logic [TS_WIDTH-1:0]  cur_sample,
    output logic [15:0]          max_metric,
    output logic [15:0]          triggers_count,
    output logic [15:0]          dropped_count,
    output logic [1:0]           state
);
    localparam int AW = ADC_DATA_WIDTH;
    localparam int PW = $clog2(PRE_DEPTH);
    localparam int SW = (AW + 3 > 17) ? AW + 3 : 17;
    localparam int DW = TS_WIDTH + 16;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARMED   = 2'd1;
    localparam logic [1:0] CAPTURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    logic [AW-1:0]       conv [NUM_CH];
    logic [AW-1:0]       s1   [NUM_CH];
    logic [AW-1:0]       mag  [NUM_CH];
    logic [AW-1:0]       a2   [NUM_CH];
    logic [SW-1:0]       sum;
    logic [TS_WIDTH-1:0] ts1, ts2, ts3;
    logic [DW-1:0]       dl [PRE_DEPTH];
    logic [PW-1:0]       wp;
    logic [DW-1:0]       dl_out;
    logic [31:0]         win_len;
    logic [PW-1:0]       fl_cnt;
    logic                flush, warm_q, warm;
    logic [15:0]         lo_eff;
    logic                trig, release_hit, limit_hit, emit, last, drop;
    logic                unused;

    assign unused = ^adc_dat;

    always_comb begin
        sum = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            conv[k] = {adc_dat[16*k+15], ~adc_dat[16*k+14 -: AW-1]};
            // The most negative code has no positive twin; clamp it.
            if (s1[k] == {1'b1, {(AW-1){1'b0}}})
                mag[k] = {1'b0, {(AW-1){1'b1}}};
            else if (s1[k][AW-1])
                mag[k] = -s1[k];
            else
                mag[k] = s1[k];
            sum = sum + SW'(a2[k]);
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int k = 0; k < NUM_CH; k++) begin
                s1[k] <= '0;
                a2[k] <= '0;
            end
            cur_metric <= '0;
            cur_sample <= '0;
            ts1 <= '0;
            ts2 <= '0;
            ts3 <= '0;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                s1[k] <= conv[k];
                a2[k] <= mag[k];
            end
            cur_metric <= (|sum[SW-1:16]) ? 16'hFFFF : sum[15:0];
            cur_sample <= cur_sample + TS_WIDTH'(1);
            ts1 <= cur_sample;
            ts2 <= ts1;
            ts3 <= ts2;
        end
    end

    // Reading before the write yields the pair stored PRE_DEPTH cycles ago.
    assign dl_out = dl[wp];

    always_ff @(posedge aclk) begin
        if (areset) begin
            for (int i = 0; i < PRE_DEPTH; i++)
                dl[i] <= '0;
            wp <= '0;
        end else begin
            dl[wp] <= {ts3, cur_metric};
            wp <= wp + PW'(1);
        end
    end

    assign warm        = warm_q | (cur_sample >= TS_WIDTH'(PRE_DEPTH + 3));
    assign lo_eff      = (level_lo > level_hi) ? level_hi : level_lo;
    assign trig        = (state == ARMED) && warm && (cur_metric > level_hi);
    assign release_hit = cur_metric < lo_eff;
    assign limit_hit   = (max_len != 32'd0) && (win_len == max_len);
    assign emit        = trig || (state == CAPTURE);
    assign last        = (state == CAPTURE) && flush && (fl_cnt == PW'(1));
    assign drop        = emit && m_axis_tvalid && !m_axis_tready;

    always_ff @(posedge aclk) begin
        if (areset) begin
            state   <= IDLE;
            warm_q  <= 1'b0;
            win_len <= '0;
            fl_cnt  <= '0;
            flush   <= 1'b0;
        end else begin
            warm_q <= warm;
            unique case (state)
                IDLE: if (warm && (auto_rearm || arm)) state <= ARMED;
                ARMED: begin
                    if (trig) begin
                        state   <= CAPTURE;
                        win_len <= 32'd1;
                        flush   <= 1'b0;
                    end
                end
                CAPTURE: begin
                    if (flush) begin
                        fl_cnt <= fl_cnt - PW'(1);
                        if (fl_cnt == PW'(1)) begin
                            flush <= 1'b0;
                            state <= auto_rearm ? ARMED : DONE;
                        end
                    end else if (limit_hit || release_hit) begin
                        flush  <= 1'b1;
                        fl_cnt <= PW'(PRE_DEPTH - 1);
                    end else begin
                        win_len <= win_len + 32'd1;
                    end
                end
                DONE: if (arm) state <= ARMED;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (emit) begin
            if (!m_axis_tvalid || m_axis_tready) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= dl_out;
                m_axis_tlast  <= last;
            end else if (last) begin
                m_axis_tdata <= dl_out;
                m_axis_tlast <= 1'b1;
            end
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            max_metric     <= '0;
            triggers_count <= '0;
            dropped_count  <= '0;
        end else if (clear_stats) begin
            max_metric     <= '0;
            triggers_count <= '0;
            dropped_count  <= '0;
        end else begin
            if (cur_metric > max_metric)
                max_metric <= cur_metric;
            if (trig && triggers_count != 16'hFFFF)
                triggers_count <= triggers_count + 16'd1;
            if (drop && dropped_count != 16'hFFFF)
                dropped_count <= dropped_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_adc_trigger_capture.sv
// Randomized directed scenarios for adc_trigger_capture, checked against a
// sample-indexed reference of metric values and capture window rules.
module tb_adc_trigger_capture;
    localparam int PRE = 16;
    localparam int NC  = 1024;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic [31:0] adc_dat = '0;
    logic [15:0] level_hi = 16'd100;
    logic [15:0] level_lo = 16'd50;
    logic [31:0] max_len = '0;
    logic        auto_rearm = 1'b1;
    logic        arm = 1'b0;
    logic        clear_stats = 1'b0;
    logic        m_axis_tready = 1'b1;
    logic        m_axis_tvalid;
    logic [63:0] m_axis_tdata;
    logic        m_axis_tlast;
    logic [15:0] cur_metric;
    logic [47:0] cur_sample;
    logic [15:0] max_metric;
    logic [15:0] triggers_count;
    logic [15:0] dropped_count;
    logic [1:0]  state;

    adc_trigger_capture dut (
        .aclk(aclk), .areset(areset), .adc_dat(adc_dat),
        .level_hi(level_hi), .level_lo(level_lo), .max_len(max_len),
        .auto_rearm(auto_rearm), .arm(arm), .clear_stats(clear_stats),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
        .cur_metric(cur_metric), .cur_sample(cur_sample),
        .max_metric(max_metric), .triggers_count(triggers_count),
        .dropped_count(dropped_count), .state(state)
    );

    always #5 aclk = ~aclk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int s0 [NC];
    int s1 [NC];
    int m  [NC];
    logic [64:0] rx [$];
    int stall_after = -1;
    logic have_hold = 1'b0;
    logic [63:0] hold = '0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int abs_sat(int v);
        if (v == -8192) return 8191;
        return (v < 0) ? -v : v;
    endfunction

    // Inverse of the lane mapping: w = {s[13], ~s[12:0]}, low 2 bits ignored.
    function automatic logic [15:0] to_raw(int v);
        logic [13:0] t;
        t = v[13:0];
        return {t[13], ~t[12:0], 2'($urandom)};
    endfunction

    function automatic void plan_lanes(int n, int a, int b);
        s0[n] = a;
        s1[n] = b;
        m[n] = abs_sat(a) + abs_sat(b);
        if (m[n] > 65535) m[n] = 65535;
    endfunction

    function automatic void plan_metric(int n, int mv);
        int a, b;
        a = int'($urandom_range(mv, 0));
        b = mv - a;
        if ($urandom_range(1, 0) == 1) a = -a;
        if ($urandom_range(1, 0) == 1) b = -b;
        plan_lanes(n, a, b);
    endfunction

    function automatic void plan_base();
        logic signed [13:0] r0, r1;
        for (int n = 0; n < 16; n++) begin
            r0 = 14'($urandom);
            r1 = 14'($urandom);
            plan_lanes(n, (n == 2) ? -8192 : int'(r0), int'(r1));
        end
        for (int n = 16; n < NC; n++)
            plan_metric(n, int'($urandom_range(40, 0)));
    endfunction

    function automatic int find_trig(int start);
        for (int n = start; n < NC; n++)
            if (m[n] > int'(level_hi)) return n;
        return -1;
    endfunction

    function automatic int win_len(int n);
        int lo;
        int k;
        lo = (level_lo > level_hi) ? int'(level_hi) : int'(level_lo);
        k = 1;
        while (1) begin
            if (max_len != 0 && k == int'(max_len)) return k;
            if (n + k >= NC || m[n + k] < lo) return k;
            k++;
        end
        return k;
    endfunction

    task automatic tick();
        if (stall_after >= 0 && rx.size() >= stall_after)
            m_axis_tready = 1'b0;
        else
            m_axis_tready = 1'b1;
        adc_dat = {to_raw(s1[cyc]), to_raw(s0[cyc])};
        chk("cur_sample", 64'(cur_sample), 64'(cyc));
        chk("cur_metric", 64'(cur_metric), 64'((cyc >= 3) ? m[cyc-3] : 0));
        if (m_axis_tvalid && m_axis_tready)
            rx.push_back({m_axis_tlast, m_axis_tdata});
        if (m_axis_tvalid && !m_axis_tready && !m_axis_tlast) begin
            if (have_hold) chk("held_tdata", m_axis_tdata, hold);
            else begin
                hold = m_axis_tdata;
                have_hold = 1'b1;
            end
        end
        @(posedge aclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_reset();
        areset = 1'b1;
        arm = 1'b0;
        clear_stats = 1'b0;
        stall_after = -1;
        m_axis_tready = 1'b1;
        repeat (2) @(posedge aclk);
        #1;
        chk("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst_tdata", m_axis_tdata, 64'd0);
        chk("rst_tlast", 64'(m_axis_tlast), 64'd0);
        chk("rst_metric", 64'(cur_metric), 64'd0);
        chk("rst_sample", 64'(cur_sample), 64'd0);
        chk("rst_max", 64'(max_metric), 64'd0);
        chk("rst_trig", 64'(triggers_count), 64'd0);
        chk("rst_drop", 64'(dropped_count), 64'd0);
        chk("rst_state", 64'(state), 64'd0);
        areset = 1'b0;
        cyc = 0;
        rx.delete();
        have_hold = 1'b0;
    endtask

    task automatic check_window(input int base, input int n, input int len,
                                input string tag);
        int nb;
        int ts;
        nb = PRE + len;
        chk({tag, "_beats"}, 64'(rx.size() - base), 64'(nb));
        for (int i = 0; i < nb && base + i < rx.size(); i++) begin
            ts = n - PRE + i;
            chk({tag, "_data"}, rx[base+i][63:0], {48'(ts), 16'(m[ts])});
            chk({tag, "_last"}, 64'(rx[base+i][64]), 64'(i == nb - 1));
        end
    endtask

    initial begin
        int q, n, n2, len, len2, a, mx, nb;
        logic [64:0] b;

        // quiet input: metric latency, stays ARMED, nothing streamed
        do_reset();
        plan_base();
        level_hi = 16'd100; level_lo = 16'd50; max_len = 0; auto_rearm = 1'b1;
        run_to(200);
        mx = 0;
        for (int i = 0; i <= cyc - 4; i++) if (m[i] > mx) mx = m[i];
        chk("s1_state", 64'(state), 64'd1);
        chk("s1_beats", 64'(rx.size()), 64'd0);
        chk("s1_trig", 64'(triggers_count), 64'd0);
        chk("s1_max", 64'(max_metric), 64'(mx));

        // 10-sample burst at 1000 then zero
        do_reset();
        plan_base();
        q = int'($urandom_range(60, 40));
        for (int i = q; i < NC; i++) plan_metric(i, (i < q + 10) ? 1000 : 0);
        run_to(q + 70);
        n = find_trig(17);
        check_window(0, n, win_len(n), "s2");
        chk("s2_count", 64'(rx.size()), 64'd26);
        if (rx.size() > 16) chk("s2_beat17", 64'(rx[16][15:0]), 64'd1000);
        chk("s2_trig", 64'(triggers_count), 64'd1);
        chk("s2_state", 64'(state), 64'd1);

        // length limit, no auto re-arm, manual arm
        do_reset();
        plan_base();
        auto_rearm = 1'b0; max_len = 5;
        q = int'($urandom_range(50, 40));
        for (int i = q; i < NC; i++) plan_metric(i, 1000);
        run_to(5);
        arm = 1'b1; tick(); arm = 1'b0;
        run_to(19);
        chk("s3_warm_idle", 64'(state), 64'd0);
        run_to(24);
        arm = 1'b1; tick(); arm = 1'b0;
        chk("s3_armed", 64'(state), 64'd1);
        run_to(q + 45);
        n = find_trig(22);
        len = win_len(n);
        check_window(0, n, len, "s3a");
        chk("s3_count", 64'(rx.size()), 64'd21);
        chk("s3_done", 64'(state), 64'd3);
        chk("s3_trig1", 64'(triggers_count), 64'd1);
        a = cyc;
        arm = 1'b1; tick(); arm = 1'b0;
        run_to(a + 45);
        // armed the cycle after the pulse; that cycle shows input a-2
        n2 = a + 1 - 3;
        len2 = win_len(n2);
        check_window(PRE + len, n2, len2, "s3b");
        chk("s3_trig2", 64'(triggers_count), 64'd2);
        chk("s3_done2", 64'(state), 64'd3);

        // backpressure from beat 3 on
        do_reset();
        plan_base();
        auto_rearm = 1'b1; max_len = 0;
        q = int'($urandom_range(60, 40));
        for (int i = q; i < NC; i++) plan_metric(i, (i < q + 10) ? 1000 : 0);
        stall_after = 2;
        run_to(q + 70);
        n = find_trig(17);
        len = win_len(n);
        nb = PRE + len;
        chk("s4_taken", 64'(rx.size()), 64'd2);
        chk("s4_drop", 64'(dropped_count), 64'(nb - 3));
        chk("s4_tvalid", 64'(m_axis_tvalid), 64'd1);
        chk("s4_tlast", 64'(m_axis_tlast), 64'd1);
        chk("s4_final", m_axis_tdata, {48'(n + len - 1), 16'(m[n + len - 1])});
        stall_after = -1;
        tick();
        tick();
        chk("s4_rx", 64'(rx.size()), 64'd3);
        for (int i = 0; i < 3 && i < rx.size(); i++) begin
            int ts;
            ts = (i < 2) ? n - PRE + i : n + len - 1;
            b = rx[i];
            chk("s4_data", b[63:0], {48'(ts), 16'(m[ts])});
            chk("s4_last", 64'(b[64]), 64'(i == 2));
        end

        // hysteresis: 120/80 alternation keeps one window open
        do_reset();
        plan_base();
        q = int'($urandom_range(60, 40));
        for (int i = q; i < NC; i++)
            plan_metric(i, (i >= q + 40) ? 0 : (((i - q) % 2 == 0) ? 120 : 80));
        run_to(q + 23);
        chk("s5_open", 64'(state), 64'd2);
        run_to(q + 100);
        n = find_trig(17);
        check_window(0, n, win_len(n), "s5");
        chk("s5_count", 64'(rx.size()), 64'd56);
        chk("s5_trig", 64'(triggers_count), 64'd1);

        // clear coincident with trigger, then reset mid-window
        do_reset();
        plan_base();
        q = int'($urandom_range(60, 40));
        for (int i = q; i < NC; i++) plan_metric(i, (i < q + 30) ? 1000 : 0);
        run_to(q + 3);
        clear_stats = 1'b1; tick(); clear_stats = 1'b0;
        chk("s6_clr_trig", 64'(triggers_count), 64'd0);
        chk("s6_clr_max", 64'(max_metric), 64'd0);
        chk("s6_capture", 64'(state), 64'd2);
        run_to(q + 12);
        chk("s6_valid", 64'(m_axis_tvalid), 64'd1);
        do_reset();
        plan_base();
        run_to(100);
        chk("s6_post_beats", 64'(rx.size()), 64'd0);
        chk("s6_post_state", 64'(state), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
